// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op encodings, instruction layout
// and the controller state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_FWD  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_NOT  = 3'd3,
        OP_OR   = 3'd4,
        OP_AND  = 3'd5,
        OP_XOR  = 3'd6,
        OP_SHL2 = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } seq_state_e;

    // Field order fixes the bit positions: [15:13] op, [12] imm_sel,
    // [11:10] rd, [9:8] rs1, [7:0] imm (rs2 lives in imm[1:0]).
    typedef struct packed {
        alu_op_e    op;
        logic       imm_sel;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [7:0] imm;
    } instr_t;

    function automatic logic [1:0] rs2Of(input instr_t i);
        return i.imm[1:0];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: one synchronous write port, two combinational read
// ports and a combinational debug read port, cleared by async reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [1:0] raddr_a_i,
    output logic [7:0] rdata_a_o,
    input  logic [1:0] raddr_b_i,
    output logic [7:0] rdata_b_o,
    input  logic [1:0] dbg_addr_i,
    output logic [7:0] dbg_data_o
);

    logic [7:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = regs_q[raddr_a_i];
    assign rdata_b_o  = regs_q[raddr_b_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Single-issue ALU sequencer: accepts one instruction at a time, drives the
// shared clocked ALU, waits out its latency and writes the result back.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int OPC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic             alu_en,
    output logic [OPC_W-1:0] alu_opcode,
    output logic [7:0]       alu_in_1,
    output logic [7:0]       alu_in_2,
    input  logic [7:0]       alu_out,
    output logic             done,
    output logic [7:0]       result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy,
    input  logic [1:0]       dbg_addr,
    output logic [7:0]       dbg_data
);

    // Last WAIT count before moving to WB; unused when ALU_LAT is 1.
    localparam logic [1:0] WAIT_LAST = (ALU_LAT >= 2) ? 2'(ALU_LAT - 2) : 2'd0;

    seq_state_e       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       rd_q;
    logic [OPC_W-1:0] alu_opcode_q;
    logic [7:0]       alu_in_1_q, alu_in_2_q;
    logic             done_q;
    logic [7:0]       result_q;
    logic             flag_z_q, flag_n_q;

    instr_t     instr_w;
    logic       accept;
    logic       wb_en;
    logic [7:0] rdata_a, rdata_b;

    assign instr_w = instr_t'(instr);
    assign accept  = instr_ready && instr_valid;
    assign wb_en   = (state_q == WB);

    // Operands are read in the accept cycle, after any previous write-back
    // has landed, so rd -> rs forwarding is never needed.
    alu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wb_en),
        .waddr_i    (rd_q),
        .wdata_i    (alu_out),
        .raddr_a_i  (instr_w.rs1),
        .rdata_a_o  (rdata_a),
        .raddr_b_i  (rs2Of(instr_w)),
        .rdata_b_o  (rdata_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d   = '0;
                state_d = (ALU_LAT == 1) ? WB : WAIT;
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        instr_ready = (state_q == IDLE);
        alu_en      = (state_q == EXEC);
        busy        = ~instr_ready;
    end

    // Opcode and operands are captured at accept and held until the next one,
    // which keeps them stable for the whole EXEC..WB window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= '0;
            alu_opcode_q <= '0;
            alu_in_1_q   <= '0;
            alu_in_2_q   <= '0;
        end else if (accept) begin
            rd_q         <= instr_w.rd;
            alu_opcode_q <= OPC_W'(instr_w.op);
            alu_in_1_q   <= rdata_a;
            alu_in_2_q   <= instr_w.imm_sel ? instr_w.imm : rdata_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            done_q <= wb_en;
            if (wb_en) begin
                result_q <= alu_out;
                flag_z_q <= (alu_out == 8'h00);
                flag_n_q <= alu_out[7];
            end
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_in_1   = alu_in_1_q;
    assign alu_in_2   = alu_in_2_q;
    assign done       = done_q;
    assign result     = result_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, each paired with a behavioural ALU and a reference register file.
module tb_alu_seq_ctrl;

    typedef struct {
        int         accCyc;
        logic [2:0] op;
        logic [7:0] in1;
        logic [7:0] in2;
        logic [1:0] rd;
        logic [7:0] val;
    } exp_t;

    logic clk;
    int   cyc;
    int   testsRun;
    int   testsFailed;

    initial begin
        clk         = 1'b0;
        cyc         = 0;
        testsRun    = 0;
        testsFailed = 0;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] aluFn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return ~a;
            3'd4:    return a | b;
            3'd5:    return a & b;
            3'd6:    return a ^ b;
            default: return {a[5:0], 2'b00};
        endcase
    endfunction

    function automatic logic [15:0] mkInstr(input logic [2:0] op, input logic immSel,
                                            input logic [1:0] rd, input logic [1:0] rs1,
                                            input logic [7:0] imm);
        return {op, immSel, rd, rs1, imm};
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rstN;
        logic        instrValid;
        logic        instrReady;
        logic [15:0] instrWord;
        logic        aluEn;
        logic [7:0]  aluOpcode;
        logic [7:0]  aluIn1;
        logic [7:0]  aluIn2;
        logic [7:0]  aluOut;
        logic        done;
        logic [7:0]  result;
        logic        flagZ;
        logic        flagN;
        logic        busy;
        logic [1:0]  dbgAddr;
        logic [7:0]  dbgData;

        logic [7:0]  aluPipe [4];
        logic [7:0]  refRegs [4];
        exp_t        expQ [$];
        int          lastAccCyc;
        bit          rstChecked;
        bit          stimDone;

        alu_seq_ctrl #(.ALU_LAT(LAT), .OPC_W(8)) dut (
            .clk         (clk),
            .rst_n       (rstN),
            .instr_valid (instrValid),
            .instr_ready (instrReady),
            .instr       (instrWord),
            .alu_en      (aluEn),
            .alu_opcode  (aluOpcode),
            .alu_in_1    (aluIn1),
            .alu_in_2    (aluIn2),
            .alu_out     (aluOut),
            .done        (done),
            .result      (result),
            .flag_z      (flagZ),
            .flag_n      (flagN),
            .busy        (busy),
            .dbg_addr    (dbgAddr),
            .dbg_data    (dbgData)
        );

        // Behavioural ALU: computes on the enable edge, result appears LAT
        // cycles after that edge counting the edge itself.
        always @(posedge clk) begin
            if (aluEn) aluPipe[0] <= aluFn(aluOpcode[2:0], aluIn1, aluIn2);
            for (int k = 1; k < 4; k++) aluPipe[k] <= aluPipe[k-1];
        end
        assign aluOut = aluPipe[LAT-1];

        always @(negedge clk) begin : monitor
            bit          accNow;
            logic [15:0] wNow;
            exp_t        e;
            exp_t        n;
            accNow = instrValid && instrReady && rstN;
            wNow   = instrWord;
            if (!rstN) begin
                if (!rstChecked) begin
                    checkOutput($sformatf("L%0d rst_ready", LAT), instrReady, 1);
                    checkOutput($sformatf("L%0d rst_alu_en", LAT), aluEn, 0);
                    checkOutput($sformatf("L%0d rst_done", LAT), done, 0);
                    checkOutput($sformatf("L%0d rst_result", LAT), result, 0);
                    checkOutput($sformatf("L%0d rst_flags", LAT), {flagZ, flagN}, 0);
                    checkOutput($sformatf("L%0d rst_operands", LAT), {aluOpcode, aluIn1, aluIn2}, 0);
                    for (int k = 0; k < 4; k++) begin
                        dbgAddr = 2'(k);
                        #1;
                        checkOutput($sformatf("L%0d rst_R%0d", LAT, k), dbgData, 0);
                    end
                end
                rstChecked = 1;
                expQ.delete();
                for (int k = 0; k < 4; k++) refRegs[k] = 8'h00;
            end else begin
                rstChecked = 0;
                checkOutput($sformatf("L%0d busy", LAT), busy, !instrReady);
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("L%0d alu_en_idle", LAT), aluEn, 0);
                    checkOutput($sformatf("L%0d done_spurious", LAT), done, 0);
                end else begin
                    e = expQ[0];
                    checkOutput($sformatf("L%0d alu_en", LAT), aluEn, int'(cyc == e.accCyc + 1));
                    if (cyc <= e.accCyc + LAT + 1) begin
                        checkOutput($sformatf("L%0d opcode", LAT), aluOpcode, {5'b0, e.op});
                        checkOutput($sformatf("L%0d in_1", LAT), aluIn1, e.in1);
                        checkOutput($sformatf("L%0d in_2", LAT), aluIn2, e.in2);
                    end
                    checkOutput($sformatf("L%0d done_timing", LAT), done, int'(cyc == e.accCyc + LAT + 2));
                    if (done || cyc >= e.accCyc + LAT + 2) begin
                        void'(expQ.pop_front());
                        if (done) begin
                            checkOutput($sformatf("L%0d result", LAT), result, e.val);
                            checkOutput($sformatf("L%0d flag_z", LAT), flagZ, int'(e.val == 8'h00));
                            checkOutput($sformatf("L%0d flag_n", LAT), flagN, e.val[7]);
                            for (int k = 0; k < 4; k++) begin
                                dbgAddr = 2'(k);
                                #1;
                                checkOutput($sformatf("L%0d R%0d", LAT, k), dbgData, refRegs[k]);
                            end
                        end
                    end
                end
                if (accNow) begin
                    n.accCyc = cyc;
                    n.op     = wNow[15:13];
                    n.rd     = wNow[11:10];
                    n.in1    = refRegs[wNow[9:8]];
                    n.in2    = wNow[12] ? wNow[7:0] : refRegs[wNow[1:0]];
                    n.val    = aluFn(n.op, n.in1, n.in2);
                    refRegs[n.rd] = n.val;
                    expQ.push_back(n);
                    lastAccCyc = cyc;
                end
            end
        end

        task automatic applyStimulus(input logic [15:0] w, input bit keepValid);
            int waited;
            waited     = 0;
            instrValid = 1'b1;
            instrWord  = w;
            forever begin
                @(negedge clk);
                if (instrReady) break;
                waited++;
                if (waited > 50) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL L%0d accept_timeout: got no ready after %0d cycles", LAT, waited);
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!keepValid) instrValid = 1'b0;
        endtask

        initial begin : stim
            int a1;
            int guard;
            stimDone   = 0;
            rstChecked = 0;
            dbgAddr    = '0;
            instrValid = 1'b0;
            instrWord  = '0;
            rstN       = 1'b1;
            #1 rstN    = 1'b0;
            repeat (3) @(posedge clk);
            #1 rstN = 1'b1;

            if (LAT == 1) begin
                applyStimulus(mkInstr(3'd1, 1'b1, 2'd1, 2'd0, 8'h3C), 0);
                applyStimulus(mkInstr(3'd2, 1'b1, 2'd2, 2'd1, 8'h3C), 0);
                applyStimulus(mkInstr(3'd2, 1'b1, 2'd3, 2'd0, 8'h01), 0);
                applyStimulus(mkInstr(3'd1, 1'b1, 2'd1, 2'd0, 8'h05), 1);
                a1 = lastAccCyc;
                applyStimulus(mkInstr(3'd7, 1'b0, 2'd2, 2'd1, 8'h00), 0);
                checkOutput("L1 zero_bubble", lastAccCyc - a1, LAT + 2);
                applyStimulus(mkInstr(3'd6, 1'b1, 2'd0, 2'd2, 8'hA5), 0);
                instrValid = 1'b1;
                instrWord  = mkInstr(3'd4, 1'b1, 2'd3, 2'd3, 8'hFF);
                @(posedge clk);
                #1 instrValid = 1'b0;
            end else begin
                applyStimulus(mkInstr(3'd3, 1'b0, 2'd1, 2'd0, 8'h00), 0);
                applyStimulus(mkInstr(3'd1, 1'b1, 2'd2, 2'd1, 8'h77), 0);
                @(posedge clk);
                #1 rstN = 1'b0;
                repeat (2) @(posedge clk);
                #1 rstN = 1'b1;
                repeat (8) @(posedge clk);
                #1;
            end

            for (int i = 0; i < 60; i++) begin
                applyStimulus(16'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            instrValid = 1'b0;

            guard = 0;
            while (expQ.size() != 0 && guard < 30) begin
                @(posedge clk);
                guard++;
            end
            repeat (3) @(posedge clk);
            checkOutput($sformatf("L%0d drain", LAT), expQ.size(), 0);
            stimDone = 1;
        end
    end

    initial begin : finisher
        int guard;
        guard = 0;
        while (!(gInst[0].stimDone && gInst[1].stimDone) && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL global_timeout: got %0d cycles, limit 20000", guard);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
